// File: rtl/scale_scan_ctrl_if.sv
// Config, memory read port and output-buffer write port of the downscaler sequencer.
// The master side is the sequencer; the slave side is the memory / buffer / control environment.
interface scale_scan_ctrl_if #(
  parameter int unsigned CW = 6,
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 8
);
  logic          start;
  logic [CW-1:0] src_w;
  logic [CW-1:0] src_h;
  logic [CW-1:0] out_w;
  logic [CW-1:0] out_h;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          err;

  modport master (
    input  start, src_w, src_h, out_w, out_h, rd_gnt, rd_data,
    output rd_req, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );

  modport slave (
    output start, src_w, src_h, out_w, out_h, rd_gnt, rd_data,
    input  rd_req, rd_addr, wr_en, wr_addr, wr_data, busy, done, err
  );
endinterface

// File: rtl/scale_scan_ctrl.sv
// Nearest-neighbour downscale sequencer: walks the source raster, keeps rows/columns
// by fractional accumulation, fetches kept pixels and writes them out in raster order.
module scale_scan_ctrl #(
  parameter int unsigned CW = 6,
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  scale_scan_ctrl_if.master bus
);

  localparam int unsigned SW = CW + 1;

  typedef enum logic [2:0] {IDLE, ROWCHK, SCAN, ROWEND, FLUSH, DONE} state_e;

  typedef struct packed {
    logic [CW-1:0] src_w;
    logic [CW-1:0] src_h;
    logic [CW-1:0] out_w;
    logic [CW-1:0] out_h;
  } cfg_t;

  state_e        state_q, state_d;
  cfg_t          cfg_q, cfg_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] acc_x_q, acc_x_d, acc_y_q, acc_y_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic          rd_req_q, rd_req_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic [SW-1:0] sum_x, sum_y, sum_xn;
  logic          keep_x, keep_y, accept, cfg_ok;

  assign sum_x  = SW'(acc_x_q) + SW'(cfg_q.out_w);
  assign sum_y  = SW'(acc_y_q) + SW'(cfg_q.out_h);
  assign keep_x = sum_x >= SW'(cfg_q.src_w);
  assign keep_y = sum_y >= SW'(cfg_q.src_h);
  assign accept = rd_req_q & bus.rd_gnt;
  assign cfg_ok = (bus.src_w != '0) && (bus.src_h != '0) && (bus.out_w != '0) &&
                  (bus.out_h != '0) && (bus.out_w <= bus.src_w) && (bus.out_h <= bus.src_h);

  // Look-ahead of the column keep decision so rd_req can be a register
  assign sum_xn = SW'(acc_x_d) + SW'(cfg_q.out_w);

  always_comb begin
    state_d    = state_q;
    cfg_d      = cfg_q;
    x_d        = x_q;
    y_d        = y_q;
    acc_x_d    = acc_x_q;
    acc_y_d    = acc_y_q;
    row_base_d = row_base_q;
    err_d      = err_q;
    wr_en_d    = accept;
    wr_addr_d  = wr_en_q ? wr_addr_q + AW'(1) : wr_addr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          cfg_d      = '{src_w: bus.src_w, src_h: bus.src_h, out_w: bus.out_w, out_h: bus.out_h};
          x_d        = '0;
          y_d        = '0;
          acc_x_d    = '0;
          acc_y_d    = '0;
          row_base_d = '0;
          wr_addr_d  = '0;
          err_d      = !cfg_ok;
          state_d    = cfg_ok ? ROWCHK : DONE;
        end
      end
      ROWCHK: state_d = keep_y ? SCAN : ROWEND;
      SCAN: begin
        // Kept columns wait for the grant; dropped columns step immediately
        if (!keep_x || accept) begin
          if (x_q == cfg_q.src_w - CW'(1)) begin
            x_d     = '0;
            acc_x_d = '0;
            state_d = ROWEND;
          end else begin
            x_d     = x_q + CW'(1);
            acc_x_d = keep_x ? CW'(sum_x - SW'(cfg_q.src_w)) : CW'(sum_x);
          end
        end
      end
      ROWEND: begin
        acc_y_d    = keep_y ? CW'(sum_y - SW'(cfg_q.src_h)) : CW'(sum_y);
        row_base_d = row_base_q + AW'(cfg_q.src_w);
        y_d        = y_q + CW'(1);
        state_d    = (y_q == cfg_q.src_h - CW'(1)) ? FLUSH : ROWCHK;
      end
      FLUSH:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    rd_req_d  = (state_d == SCAN) && (sum_xn >= SW'(cfg_q.src_w));
    rd_addr_d = rd_req_d ? row_base_d + AW'(x_d) : '0;
    busy_d    = state_d != IDLE;
    done_d    = state_d == DONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      acc_x_q    <= '0;
      acc_y_q    <= '0;
      row_base_q <= '0;
      rd_req_q   <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      x_q        <= x_d;
      y_q        <= y_d;
      acc_x_q    <= acc_x_d;
      acc_y_q    <= acc_y_d;
      row_base_q <= row_base_d;
      rd_req_q   <= rd_req_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.rd_req  = rd_req_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = bus.rd_data;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_scale_scan_ctrl.sv
// Scoreboard bench for scale_scan_ctrl: directed configurations push expected reads,
// writes and completion status; a negedge monitor/memory model pops and compares.
module tb_scale_scan_ctrl;
  localparam int unsigned CW = 6;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  scale_scan_ctrl_if #(.CW(CW), .AW(AW), .DW(DW)) bus ();
  scale_scan_ctrl #(.CW(CW), .AW(AW), .DW(DW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_err = 0;
  int exp_rd[$];
  int exp_wa[$];
  int exp_wd[$];
  int exp_err[$];
  int gnt_delay = 0;
  int wait_cnt  = 0;
  int done_cnt  = 0;
  int wr_idx    = 0;
  bit prev_wait = 1'b0;
  int prev_addr = 0;

  int t1_addr[4] = '{5, 7, 13, 15};
  int t3_addr[8] = '{2, 4, 7, 9, 12, 14, 17, 19};

  function automatic int mem_val(int a);
    return (a * 7 + 3) % 256;
  endfunction

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_pix(int a);
    exp_rd.push_back(a);
    exp_wa.push_back(wr_idx);
    exp_wd.push_back(mem_val(a));
    wr_idx++;
  endtask

  // Monitor, grant generator and memory model share one process so ordering is fixed
  always @(negedge clk) begin
    if (rst) begin
      wait_cnt   = 0;
      prev_wait  = 1'b0;
      bus.rd_gnt = 1'b0;
    end else begin
      if (prev_wait) begin
        chk("rd_req_hold", int'(bus.rd_req), 1);
        chk("rd_addr_hold", int'(bus.rd_addr), prev_addr);
      end
      if (bus.wr_en) begin
        n_chk++;
        if (exp_wa.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_wr: got wr_addr %0d expected no write", int'(bus.wr_addr));
        end else begin
          n_chk--;
          chk("wr_addr", int'(bus.wr_addr), exp_wa.pop_front());
          chk("wr_data", int'(bus.wr_data), exp_wd.pop_front());
        end
      end
      if (bus.done) begin
        done_cnt++;
        n_chk++;
        if (exp_err.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_done: got done=1 expected 0");
        end else begin
          n_chk--;
          chk("err_at_done", int'(bus.err), exp_err.pop_front());
          chk("reads_left_at_done", exp_rd.size(), 0);
          chk("writes_left_at_done", exp_wa.size(), 0);
        end
      end
      if (gnt_delay == 0) begin
        bus.rd_gnt = 1'b1;
      end else if (bus.rd_req) begin
        if (wait_cnt >= gnt_delay) begin
          bus.rd_gnt = 1'b1;
          wait_cnt   = 0;
        end else begin
          bus.rd_gnt = 1'b0;
          wait_cnt++;
        end
      end else begin
        bus.rd_gnt = 1'b0;
        wait_cnt   = 0;
      end
      if (bus.rd_req && bus.rd_gnt) begin
        n_chk++;
        if (exp_rd.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rd: got rd_addr %0d expected no read", int'(bus.rd_addr));
        end else begin
          n_chk--;
          chk("rd_addr", int'(bus.rd_addr), exp_rd.pop_front());
        end
        bus.rd_data = DW'(mem_val(int'(bus.rd_addr)));
      end
      prev_wait = bus.rd_req && !bus.rd_gnt;
      prev_addr = int'(bus.rd_addr);
    end
  end

  task automatic run(int sw, int sh, int ow, int oh, bit bad, int mid_start);
    int base;
    base = done_cnt;
    @(negedge clk);
    bus.src_w = CW'(sw);
    bus.src_h = CW'(sh);
    bus.out_w = CW'(ow);
    bus.out_h = CW'(oh);
    bus.start = 1'b1;
    @(negedge clk);
    #1;
    bus.start = 1'b0;
    if (bad) begin
      chk("done_after_start", int'(bus.done), 1);
      chk("err_after_start", int'(bus.err), 1);
    end else begin
      chk("busy_after_start", int'(bus.busy), 1);
    end
    for (int i = 0; i < 3000 && done_cnt == base; i++) begin
      @(negedge clk);
      #1;
      if (i == mid_start) begin
        bus.start = 1'b1;
        bus.src_w = CW'(3);
        bus.out_w = CW'(3);
      end else begin
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
    chk("done_count", done_cnt - base, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int found;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.src_w = '0;
    bus.src_h = '0;
    bus.out_w = '0;
    bus.out_h = '0;
    bus.rd_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_rd_req", int'(bus.rd_req), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_wr_addr", int'(bus.wr_addr), 0);
    rst = 1'b0;

    // 4x4 -> 2x2, grant tied high
    wr_idx = 0;
    foreach (t1_addr[i]) push_pix(t1_addr[i]);
    exp_err.push_back(0);
    run(4, 4, 2, 2, 1'b0, -1);

    // 3x3 identity
    wr_idx = 0;
    for (int a = 0; a < 9; a++) push_pix(a);
    exp_err.push_back(0);
    run(3, 3, 3, 3, 1'b0, -1);

    // 5x4 -> 2x4 with slow grants
    gnt_delay = 3;
    wr_idx = 0;
    foreach (t3_addr[i]) push_pix(t3_addr[i]);
    exp_err.push_back(0);
    run(5, 4, 2, 4, 1'b0, -1);
    gnt_delay = 0;

    // Invalid configurations
    exp_err.push_back(1);
    run(4, 4, 6, 2, 1'b1, -1);
    exp_err.push_back(1);
    run(4, 0, 2, 2, 1'b1, -1);

    // Start pulsed mid-run must not disturb the result
    wr_idx = 0;
    foreach (t1_addr[i]) push_pix(t1_addr[i]);
    exp_err.push_back(0);
    run(4, 4, 2, 2, 1'b0, 4);

    // Reset while a request waits for its grant
    gnt_delay = 3;
    wr_idx = 0;
    for (int a = 0; a < 9; a++) push_pix(a);
    exp_err.push_back(0);
    @(negedge clk);
    bus.src_w = CW'(3);
    bus.src_h = CW'(3);
    bus.out_w = CW'(3);
    bus.out_h = CW'(3);
    bus.start = 1'b1;
    @(negedge clk);
    #1;
    bus.start = 1'b0;
    found = 0;
    for (int i = 0; i < 50 && found == 0; i++) begin
      @(negedge clk);
      #2;
      if (bus.rd_req && !bus.rd_gnt) found = 1;
    end
    chk("wait_for_gnt_reached", found, 1);
    rst = 1'b1;
    #1;
    chk("abort_rd_req", int'(bus.rd_req), 0);
    chk("abort_rd_addr", int'(bus.rd_addr), 0);
    chk("abort_wr_en", int'(bus.wr_en), 0);
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    exp_rd.delete();
    exp_wa.delete();
    exp_wd.delete();
    exp_err.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    gnt_delay = 0;

    wr_idx = 0;
    foreach (t1_addr[i]) push_pix(t1_addr[i]);
    exp_err.push_back(0);
    run(4, 4, 2, 2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
